// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared prescaled period counter (edge or center aligned)
// drives CHANNELS compare outputs whose duties are double-buffered per period.
module pwm_multi #(
    parameter int N          = 8,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 16,
    parameter int AW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [N-1:0]          period,
    input  logic                  mode,
    input  logic [CHANNELS-1:0]   ch_ena,
    input  logic                  duty_wr_en,
    input  logic [AW-1:0]         duty_wr_addr,
    input  logic [N-1:0]          duty_wr_data,
    output logic [CHANNELS-1:0]   out,
    output logic                  period_end,
    output logic [N-1:0]          counter
);

    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [N-1:0]          counter_q, counter_d;
    dir_t                  dir_q, dir_d;
    logic [N-1:0]          duty_shadow_q [CHANNELS];
    logic [N-1:0]          duty_shadow_d [CHANNELS];
    logic [N-1:0]          duty_act_q    [CHANNELS];
    logic [N-1:0]          duty_act_d    [CHANNELS];
    logic [N-1:0]          period_act_q, period_act_d;
    logic                  mode_act_q, mode_act_d;
    logic [CHANNELS-1:0]   out_q, out_d;
    logic                  period_end_q, period_end_d;
    logic                  tick;
    logic                  boundary;

    always_comb begin
        tick     = ena && (pre_cnt_q >= prescale);
        boundary = 1'b0;
        // Center mode with P=0 never leaves 0, so every tick closes a period.
        if (mode_act_q) begin
            if (period_act_q == '0) begin
                boundary = tick;
            end else begin
                boundary = tick && (dir_q == DIR_DOWN) && (counter_q == N'(1));
            end
        end else begin
            boundary = tick && (counter_q == period_act_q);
        end
    end

    always_comb begin
        duty_shadow_d = duty_shadow_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (duty_wr_en && (duty_wr_addr == AW'(i))) begin
                duty_shadow_d[i] = duty_wr_data;
            end
        end

        pre_cnt_d    = pre_cnt_q;
        counter_d    = counter_q;
        dir_d        = dir_q;
        duty_act_d   = duty_act_q;
        period_act_d = period_act_q;
        mode_act_d   = mode_act_q;
        out_d        = '0;
        period_end_d = boundary;

        if (!ena) begin
            pre_cnt_d    = '0;
            counter_d    = '0;
            dir_d        = DIR_UP;
            duty_act_d   = duty_shadow_d;
            period_act_d = period;
            mode_act_d   = mode;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                out_d[i] = ch_ena[i] && (counter_q < duty_act_q[i]);
            end
            if (tick) begin
                pre_cnt_d = '0;
                // Shadow value including a same-cycle write lands in the active set.
                if (boundary) begin
                    counter_d    = '0;
                    dir_d        = DIR_UP;
                    duty_act_d   = duty_shadow_d;
                    period_act_d = period;
                    mode_act_d   = mode;
                end else if (mode_act_q && (dir_q == DIR_DOWN)) begin
                    counter_d = counter_q - N'(1);
                end else begin
                    counter_d = counter_q + N'(1);
                    if (mode_act_q && (counter_d == period_act_q)) begin
                        dir_d = DIR_DOWN;
                    end
                end
            end else begin
                pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q    <= '0;
            counter_q    <= '0;
            dir_q        <= DIR_UP;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_shadow_q[i] <= '0;
                duty_act_q[i]    <= '0;
            end
            period_act_q <= period;
            mode_act_q   <= mode;
            out_q        <= '0;
            period_end_q <= 1'b0;
        end else begin
            pre_cnt_q     <= pre_cnt_d;
            counter_q     <= counter_d;
            dir_q         <= dir_d;
            duty_shadow_q <= duty_shadow_d;
            duty_act_q    <= duty_act_d;
            period_act_q  <= period_act_d;
            mode_act_q    <= mode_act_d;
            out_q         <= out_d;
            period_end_q  <= period_end_d;
        end
    end

    assign out        = out_q;
    assign period_end = period_end_q;
    assign counter    = counter_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: a 4-channel and a 3-channel instance share stimulus
// and are checked against a position-in-period reference model.
module tb_pwm_multi;

    typedef struct packed {
        logic [3:0] out;
        logic       pe;
        logic [7:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [15:0] prescale;
    logic [7:0]  period;
    logic        mode;
    logic [3:0]  ch_ena;
    logic        duty_wr_en;
    logic [1:0]  duty_wr_addr;
    logic [7:0]  duty_wr_data;
    logic [3:0]  out4;
    logic [2:0]  out3;
    logic        pe4, pe3;
    logic [7:0]  counter4, counter3;

    int total = 0;
    int bad   = 0;

    int         m_pre    [2];
    int         m_pos    [2];
    int         m_p      [2];
    logic       m_mode   [2];
    logic [7:0] m_shadow [2][4];
    logic [7:0] m_act    [2][4];
    int         ch_count [2] = '{4, 3};
    exp_t       exp_q4[$];
    exp_t       exp_q3[$];

    pwm_multi #(.N(8), .CHANNELS(4), .PRESCALE_W(16)) u_dut4 (
        .clk(clk), .rst(rst), .ena(ena), .prescale(prescale), .period(period),
        .mode(mode), .ch_ena(ch_ena), .duty_wr_en(duty_wr_en),
        .duty_wr_addr(duty_wr_addr), .duty_wr_data(duty_wr_data),
        .out(out4), .period_end(pe4), .counter(counter4)
    );

    pwm_multi #(.N(8), .CHANNELS(3), .PRESCALE_W(16)) u_dut3 (
        .clk(clk), .rst(rst), .ena(ena), .prescale(prescale), .period(period),
        .mode(mode), .ch_ena(ch_ena[2:0]), .duty_wr_en(duty_wr_en),
        .duty_wr_addr(duty_wr_addr), .duty_wr_data(duty_wr_data),
        .out(out3), .period_end(pe3), .counter(counter3)
    );

    always #5 clk = ~clk;

    // Counter value for a given tick position inside the current period.
    function automatic int cnt_of(int pos, int p, logic md);
        if (!md || pos <= p) return pos;
        return 2 * p - pos;
    endfunction

    function automatic int len_of(int p, logic md);
        if (!md) return p + 1;
        return (p == 0) ? 1 : 2 * p;
    endfunction

    task automatic model_step(input int m);
        exp_t e;
        int   cur;
        bit   tick;
        bit   bnd;
        e   = '0;
        cur = cnt_of(m_pos[m], m_p[m], m_mode[m]);
        if (rst) begin
            m_pre[m] = 0;
            m_pos[m] = 0;
            for (int i = 0; i < 4; i++) begin
                m_shadow[m][i] = '0;
                m_act[m][i]    = '0;
            end
            m_p[m]    = int'(period);
            m_mode[m] = mode;
        end else begin
            if (duty_wr_en && int'(duty_wr_addr) < ch_count[m]) m_shadow[m][duty_wr_addr] = duty_wr_data;
            if (!ena) begin
                m_pre[m]  = 0;
                m_pos[m]  = 0;
                m_act[m]  = m_shadow[m];
                m_p[m]    = int'(period);
                m_mode[m] = mode;
            end else begin
                tick = m_pre[m] >= int'(prescale);
                for (int i = 0; i < ch_count[m]; i++) e.out[i] = ch_ena[i] && (cur < int'(m_act[m][i]));
                bnd  = tick && (m_pos[m] == len_of(m_p[m], m_mode[m]) - 1);
                e.pe = bnd;
                if (tick) begin
                    m_pre[m] = 0;
                    if (bnd) begin
                        m_pos[m]  = 0;
                        m_act[m]  = m_shadow[m];
                        m_p[m]    = int'(period);
                        m_mode[m] = mode;
                    end else begin
                        m_pos[m]++;
                    end
                end else begin
                    m_pre[m]++;
                end
            end
        end
        e.cnt = 8'(cnt_of(m_pos[m], m_p[m], m_mode[m]));
        if (m == 0) exp_q4.push_back(e);
        else exp_q3.push_back(e);
    endtask

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got=%0h want=%0h", name, $time, got, want);
        end
    endtask

    // Inputs are set at the falling edge; expectation for the next rising edge is queued.
    task automatic run_cycle();
        model_step(0);
        model_step(1);
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input int n);
        repeat (n) run_cycle();
    endtask

    task automatic write_duty(input int addr, input int data);
        duty_wr_en   = 1'b1;
        duty_wr_addr = 2'(addr);
        duty_wr_data = 8'(data);
        run_cycle();
        duty_wr_en   = 1'b0;
    endtask

    task automatic random_cycle();
        rst = ($urandom_range(0, 299) == 0);
        ena = ($urandom_range(0, 19) != 0);
        if ($urandom_range(0, 39) == 0) prescale = 16'($urandom_range(0, 3));
        if ($urandom_range(0, 59) == 0) period = 8'($urandom_range(0, 12));
        if ($urandom_range(0, 79) == 0) mode = ~mode;
        if ($urandom_range(0, 29) == 0) ch_ena = 4'($urandom_range(0, 15));
        duty_wr_en   = ($urandom_range(0, 5) == 0);
        duty_wr_addr = 2'($urandom_range(0, 3));
        duty_wr_data = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom_range(0, 14));
        run_cycle();
    endtask

    // Monitor: outputs are registered, so each rising edge presents one result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q4.size() > 0) begin
                e = exp_q4.pop_front();
                check_output("out4", 32'(out4), 32'(e.out));
                check_output("period_end4", 32'(pe4), 32'(e.pe));
                check_output("counter4", 32'(counter4), 32'(e.cnt));
            end
            if (exp_q3.size() > 0) begin
                e = exp_q3.pop_front();
                check_output("out3", 32'(out3), 32'(e.out[2:0]));
                check_output("period_end3", 32'(pe3), 32'(e.pe));
                check_output("counter3", 32'(counter3), 32'(e.cnt));
            end
        end
    end

    initial begin
        rst = 1'b1; ena = 1'b1; prescale = '0; period = 8'd9; mode = 1'b0;
        ch_ena = 4'hF; duty_wr_en = 1'b0; duty_wr_addr = '0; duty_wr_data = '0;
        @(negedge clk);
        apply_stimulus(2);
        rst = 1'b0;
        ena = 1'b0;
        write_duty(0, 0);
        write_duty(1, 3);
        write_duty(2, 10);
        write_duty(3, 255);
        ena = 1'b1;
        apply_stimulus(40);

        prescale = 16'd2; period = 8'd4;
        write_duty(1, 2);
        apply_stimulus(50);

        prescale = '0; mode = 1'b1;
        apply_stimulus(20);
        write_duty(1, 2);
        write_duty(2, 5);
        apply_stimulus(40);

        mode = 1'b0; period = 8'd9;
        write_duty(0, 3);
        apply_stimulus(30);
        write_duty(0, 7);
        apply_stimulus(25);
        period = 8'd4;
        apply_stimulus(20);

        ena = 1'b0;
        apply_stimulus(3);
        ena = 1'b1; ch_ena = 4'b0101;
        apply_stimulus(30);
        ch_ena = 4'hF;
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        apply_stimulus(20);

        repeat (2000) random_cycle();

        rst = 1'b0; ena = 1'b1; duty_wr_en = 1'b0;
        repeat (3) @(negedge clk);
        check_output("queue_drain", 32'(exp_q4.size() + exp_q3.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Multi-channel PWM generator and the parametrised successor of the single-channel PWM. One shared period counter drives CHANNELS compare outputs. The counter has a programmable prescaler, a programmable period, and edge-aligned or center-aligned counting. Duty writes go through per-channel shadow registers and are applied only at a period boundary, so outputs never glitch mid-period.

Parameters:
N, 8, counter/duty/period width
CHANNELS, 4, number of PWM outputs
PRESCALE_W, 16, prescaler width
AW, max(1,$clog2(CHANNELS)), duty write address width (derived)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
ena  input  1  global enable
prescale  input  PRESCALE_W  counter advances once every prescale+1 clocks
period  input  N  top count P
mode  input  1  0 = edge-aligned, 1 = center-aligned
ch_ena  input  CHANNELS  per-channel output enable
duty_wr_en  input  1  duty shadow write strobe
duty_wr_addr  input  AW  channel index
duty_wr_data  input  N  duty value
out  output  CHANNELS  PWM outputs, registered
period_end  output  1  one-cycle pulse after each period boundary
counter  output  N  current counter value

Behaviour:
- Reset (rst=1), all in one clock:
  - counter=0, dir=up, pre_cnt=0.
  - All duty shadow and active registers = 0.
  - period_act = period, mode_act = mode.
  - out=0, period_end=0.
  - rst has priority over every other input, including mid-period.
- Prescaler:
  - tick = ena & (pre_cnt >= prescale).
  - On tick, pre_cnt goes to 0; otherwise, while ena=1, pre_cnt increments.
  - prescale=0 gives a tick every clock.
  - The >= compare makes a prescale reduced below pre_cnt tick on the next clock.
- Edge mode (mode_act=0), on each tick:
  - counter = (counter == period_act) ? 0 : counter+1.
  - Boundary tick = tick with counter == period_act.
  - Period length = P+1 ticks.
- Center mode (mode_act=1), on each tick:
  - Counter sequence is 0,1..P,P-1..1, then repeats.
  - dir goes down when counter reaches period_act; the counter moves 1 to 0 while dir is down, then dir returns to up.
  - Boundary tick = tick with dir down and counter == 1.
  - Period length = 2P ticks.
  - P=0: counter stays 0 and every tick is a boundary; P=1 gives 0,1,0,1.
- On a boundary tick, all three take effect from the next counter value:
  - duty_act[i] = duty_shadow[i]
  - period_act = period
  - mode_act = mode
  - Switching mode at a boundary restarts at counter 0, dir up.
- Duty write:
  - duty_wr_en=1 with duty_wr_addr < CHANNELS writes duty_shadow[addr] at the clock edge.
  - Addresses >= CHANNELS are ignored.
  - A write in the same cycle as a boundary tick bypasses to duty_act, so the new value applies to the coming period.
  - Shadow writes are accepted while ena=0.
- ena=0:
  - Clock by clock: pre_cnt=0, counter=0, dir=up, out=0, period_end=0.
  - duty_act, period_act and mode_act track the shadow/inputs every cycle.
  - After ena returns to 1, the first tick occurs after prescale+1 clocks, starting from counter 0.
- Output, one-clock latency: out[i](t+1) = ena & ch_ena[i] & (counter < duty_act[i]), all evaluated at cycle t.
  - duty=0: never high.
  - Edge mode: high for min(d, P+1) ticks per period; d > P is constant high.
  - Center mode: high for 2d-1 ticks per period, centered on counter=0; d > P is constant high.
- period_end = registered boundary tick: exactly one clock wide, one clock after the boundary tick.
- counter is a direct register output; no latency.
- Widths: counter+1 never overflows because it wraps at period_act ≤ 2^N-1. All compares are unsigned N-bit.

Test Plan:
- Edge mode, N=8, prescale=0, P=9, duties {0,3,10,255}, ch_ena=4'hF:
  - out[0] constantly 0; out[1] high 3 of every 10 clocks.
  - out[2] and out[3] constantly 1 after the first clock.
  - period_end pulses every 10 clocks.
- Prescaler: prescale=2, P=4, duty=2:
  - counter advances every 3 clocks.
  - out high 6 of every 15 clocks; period_end every 15 clocks.
- Center mode, prescale=0, P=4:
  - counter sequence 0,1,2,3,4,3,2,1 repeats.
  - duty=2 gives out high 3 consecutive clocks around counter 0; duty=5 gives constant 1.
  - period_end every 8 clocks.
- Shadow update, edge mode, P=9, ch0 duty 3:
  - Write 7 at counter=4: out pulse width stays 3 until the boundary, then becomes 7.
  - Write 5 in the boundary-tick cycle: width 5 applies in the very next period.
  - Change P to 4 mid-period: takes effect only at the next boundary.
- Enables and reset:
  - ena=0 mid-period: out=0 and counter=0 on the next clock; re-enable restarts at counter 0.
  - ch_ena=4'b0101: only out[0] and out[2] toggle.
  - rst mid-period: all duties read as 0 after reset, out stays 0.
- CHANNELS=3, AW=2: a write to addr 3 is ignored; all three channels are unchanged.
